// File: rtl/p4_meta_join_pkg.sv
// Shared types for the P4 metadata join stage.
// Other files pull these in with import p4_meta_join_pkg::*.
package p4_meta_join_pkg;

    localparam int USER_META_DATA_WIDTH = 12;
    localparam int STAT_W               = 32;

    typedef logic [USER_META_DATA_WIDTH-1:0] meta_t;

    // WAIT_META: no metadata at the FIFO head yet, so the input is stalled.
    // PASS:      forward the current packet with its metadata on tuser.
    // DROP:      sink the current packet.
    typedef enum logic [1:0] {
        WAIT_META = 2'd0,
        PASS      = 2'd1,
        DROP      = 2'd2
    } state_e;

endpackage

// File: rtl/p4_meta_fifo.sv
// Synchronous metadata FIFO for p4_meta_join.
// A push while full is accepted only if a pop happens in the same cycle.
// Otherwise the push is lost and the sticky overflow flag is raised.
// A new entry reaches the head one cycle after its push; there is no bypass.
// head_next shows the entry behind the head. The join FSM reads it so that
// it can choose the next packet's path on the same edge that pops the head.
module p4_meta_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           head_next,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign count     = cnt;
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + CW'(1);
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - CW'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array. Contents are valid only where cnt says they are, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/p4_meta_join.sv
// p4_meta_join: joins per-packet metadata pulses with the packets of the
// engine's AXI-Stream output. Kept packets leave on m_axis with the metadata
// on tuser. Packets whose metadata drop bit is set are discarded.
// Optional feature: define P4_META_JOIN_STATS_EN to build live
// pkt_count/drop_count registers. Without it both outputs are tied to zero.
// Handshake: a beat transfers on any edge where valid && ready are both high.
// A valid source keeps its payload stable until that transfer, and ready may
// depend on valid. s_axis_tready reaches m_axis_tready combinationally
// (through out_rdy) so that the stage keeps full throughput.
// state_dbg exposes the join FSM state.
module p4_meta_join #(
    parameter int TDATA_NUM_BYTES      = 4,
    parameter int TID_WIDTH            = 11,
    parameter int USER_META_DATA_WIDTH = p4_meta_join_pkg::USER_META_DATA_WIDTH,
    parameter int META_FIFO_DEPTH      = 8,
    parameter int DROP_BIT             = 0
) (
    input  logic                                s_axis_aclk,
    input  logic                                s_axis_areset,
    input  logic [USER_META_DATA_WIDTH-1:0]     meta_in,
    input  logic                                meta_in_valid,
    input  logic [TDATA_NUM_BYTES*8-1:0]        s_axis_tdata,
    input  logic [TDATA_NUM_BYTES-1:0]          s_axis_tkeep,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    input  logic [TID_WIDTH-1:0]                s_axis_tid,
    output logic                                s_axis_tready,
    output logic [TDATA_NUM_BYTES*8-1:0]        m_axis_tdata,
    output logic [TDATA_NUM_BYTES-1:0]          m_axis_tkeep,
    output logic [TID_WIDTH-1:0]                m_axis_tid,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    output logic [USER_META_DATA_WIDTH-1:0]     m_axis_tuser,
    input  logic                                m_axis_tready,
    output logic                                meta_overflow,
    output logic [p4_meta_join_pkg::STAT_W-1:0] pkt_count,
    output logic [p4_meta_join_pkg::STAT_W-1:0] drop_count,
    output logic [1:0]                          state_dbg
);

    import p4_meta_join_pkg::*;

    localparam int CW = $clog2(META_FIFO_DEPTH) + 1;

    state_e                          state;
    logic [USER_META_DATA_WIDTH-1:0] fifo_head;
    logic [USER_META_DATA_WIDTH-1:0] fifo_head_next;
    logic                            fifo_empty;
    logic                            fifo_full;
    logic [CW-1:0]                   fifo_count;
    logic                            out_rdy;
    logic                            s_hs;
    logic                            pass_hs;
    logic                            pkt_done;
    logic                            next_meta_ready;

    assign out_rdy         = !m_axis_tvalid || m_axis_tready;
    assign s_hs            = s_axis_tvalid && s_axis_tready;
    assign pass_hs         = s_hs && (state == PASS);
    assign pkt_done        = s_hs && s_axis_tlast && (state != WAIT_META);
    // The entry behind the head is usable once the current packet pops the head.
    assign next_meta_ready = (fifo_count >= CW'(2));
    assign state_dbg       = state;

    p4_meta_fifo #(
        .WIDTH (USER_META_DATA_WIDTH),
        .DEPTH (META_FIFO_DEPTH)
    ) u_meta_fifo (
        .clk       (s_axis_aclk),
        .rst       (s_axis_areset),
        .push      (meta_in_valid),
        .push_data (meta_in),
        .pop       (pkt_done),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count),
        .overflow  (meta_overflow)
    );

    // Input ready: stall until metadata exists, pace to the output in PASS, and always accept in DROP.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            WAIT_META: s_axis_tready = 1'b0;
            PASS:      s_axis_tready = out_rdy;
            DROP:      s_axis_tready = 1'b1;
            default:   s_axis_tready = 1'b0;
        endcase
    end

    // Join FSM. On a tlast the next packet's path is taken from the entry behind the head, so there is no bubble.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state <= WAIT_META;
        end else begin
            case (state)
                WAIT_META: begin
                    if (!fifo_empty) begin
                        state <= fifo_head[DROP_BIT] ? DROP : PASS;
                    end
                end
                PASS, DROP: begin
                    if (pkt_done) begin
                        if (next_meta_ready) begin
                            state <= fifo_head_next[DROP_BIT] ? DROP : PASS;
                        end else begin
                            state <= WAIT_META;
                        end
                    end
                end
                default: state <= WAIT_META;
            endcase
        end
    end

    // Output register. It loads on every PASS handshake and holds while downstream stalls.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tid    <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (out_rdy) begin
            m_axis_tvalid <= pass_hs;
            if (pass_hs) begin
                m_axis_tdata <= s_axis_tdata;
                m_axis_tkeep <= s_axis_tkeep;
                m_axis_tid   <= s_axis_tid;
                m_axis_tlast <= s_axis_tlast;
                m_axis_tuser <= fifo_head;
            end
        end
    end

`ifdef P4_META_JOIN_STATS_EN
    // Packet statistics. The counters wrap naturally at 2^32.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else if (pkt_done) begin
            if (state == PASS) begin
                pkt_count <= pkt_count + STAT_W'(1);
            end else begin
                drop_count <= drop_count + STAT_W'(1);
            end
        end
    end
`else
    assign pkt_count  = '0;
    assign drop_count = '0;
`endif

endmodule
